// File: rtl/cpu_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
// Holds opcode and FSM state types plus the default operand width.
package cpu_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Purely combinational, no flow control; the caller sequences the steps.
module muldiv_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;

  always_comb begin
    acc_next = '0;
    // Multiply: upper half accumulates the multiplicand, multiplier bits drain out of the low end.
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    // Divide: upper half is the running remainder, quotient bits enter at the low end.
    partial  = acc[2*WIDTH-1:WIDTH-1];
    diff     = partial - {1'b0, operand};
    if (is_div) begin
      if (!diff[WIDTH]) begin
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {partial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU owning HI/LO; result lands WIDTH+1 cycles after START.
// BUSY holds off new ops and MT writes; STALL = BUSY & RD_REQ holds the pipeline.
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] SRC_A,
  input  logic [WIDTH-1:0] SRC_B,
  input  logic             MTHI,
  input  logic             MTLO,
  input  logic             RD_REQ,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             BUSY,
  output logic             STALL
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state;
  state_e             state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               is_div;
  logic               sign_q;
  logic               sign_r;
  logic               op_signed;
  logic               op_div;

  assign op_signed = (OP == OP_MULT) || (OP == OP_DIV);
  assign op_div    = (OP == OP_DIV)  || (OP == OP_DIVU);
  assign a_abs     = (op_signed && SRC_A[WIDTH-1]) ? -SRC_A : SRC_A;
  assign b_abs     = (op_signed && SRC_B[WIDTH-1]) ? -SRC_B : SRC_B;

  // Sign fixup applied in the FIX cycle; signed overflow wraps to 0x80..0 naturally.
  assign prod_fix  = sign_q ? -acc : acc;
  assign quo_fix   = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix   = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (opnd),
    .is_div   (is_div),
    .acc_next (acc_step)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (START) state_nxt = S_RUN;
      S_RUN:   if (cnt == LAST) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      is_div <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (START) begin
            cnt    <= '0;
            is_div <= op_div;
            sign_q <= op_signed & (SRC_A[WIDTH-1] ^ SRC_B[WIDTH-1]);
            sign_r <= op_signed & SRC_A[WIDTH-1];
            // Divide: dividend sits in the low half; multiply: multiplier does.
            if (op_div) begin
              acc  <= {{WIDTH{1'b0}}, a_abs};
              opnd <= b_abs;
            end else begin
              acc  <= {{WIDTH{1'b0}}, b_abs};
              opnd <= a_abs;
            end
          end else begin
            if (MTHI) hi_q <= SRC_A;
            if (MTLO) lo_q <= SRC_A;
          end
        end
        S_RUN: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign HI    = hi_q;
  assign LO    = lo_q;
  assign BUSY  = (state != S_IDLE);
  assign STALL = BUSY & RD_REQ;

endmodule
